// File: rtl/cache_control.sv
// cache_control: two-way cache controller FSM (CHECK/WRITEBACK/ALLOCATE) with
// victim/replay tracking and saturating hit/miss counters.
module cache_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        d_out0,
    input  logic        d_out1,
    input  logic        lru_out,
    output logic        load_lru,
    output logic        lru_in,
    output logic        pmemwdata_sel,
    output logic        load_d0,
    output logic        load_v0,
    output logic        load_TD0,
    output logic        d_in0,
    output logic        v_in0,
    output logic        load_d1,
    output logic        load_v1,
    output logic        load_TD1,
    output logic        d_in1,
    output logic        v_in1,
    output logic [1:0]  pmemaddr_sel,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;
    state_t state, next_state;
    logic victim, replay;
    logic [1:0] ld_td, ld_d, dn, ld_v, vn;
    logic req, hit, hitway, miss, victim_dirty;

    // The replayed access is forced to hit the freshly filled victim way.
    assign req          = mem_read | mem_write;
    assign hit          = replay | hit0 | hit1;
    assign hitway       = replay ? victim : ~hit0;
    assign miss         = (state == CHECK) & req & ~hit;
    assign victim_dirty = lru_out ? d_out1 : d_out0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CHECK;
            victim <= 1'b0;
            replay <= 1'b0;
        end else begin
            state  <= next_state;
            victim <= miss ? lru_out : victim;
            replay <= (state == ALLOCATE && pmem_resp) ? 1'b1 : (state == CHECK) ? 1'b0 : replay;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == CHECK && req && hit && !replay && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CHECK:     next_state = miss ? (victim_dirty ? WRITEBACK : ALLOCATE) : CHECK;
            WRITEBACK: next_state = pmem_resp ? ALLOCATE : WRITEBACK;
            ALLOCATE:  next_state = pmem_resp ? CHECK : ALLOCATE;
            default:   next_state = CHECK;
        endcase
    end

    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        pmemwdata_sel = 1'b0;
        pmemaddr_sel  = 2'b00;
        ld_td         = 2'b00;
        ld_d          = 2'b00;
        dn            = 2'b00;
        ld_v          = 2'b00;
        vn            = 2'b00;
        case (state)
            CHECK: begin
                if (req && hit) begin
                    mem_resp      = 1'b1;
                    pmemwdata_sel = hitway;
                    load_lru      = 1'b1;
                    lru_in        = ~hitway;
                    ld_td[hitway] = mem_write;
                    ld_d[hitway]  = mem_write;
                    dn[hitway]    = mem_write;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmemaddr_sel  = victim ? 2'b10 : 2'b01;
                pmemwdata_sel = victim;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                // A reset arriving with the fill response aborts without loading the way.
                if (pmem_resp && !rst) begin
                    ld_td[victim] = 1'b1;
                    ld_v[victim]  = 1'b1;
                    vn[victim]    = 1'b1;
                    ld_d[victim]  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign {load_TD1, load_TD0} = ld_td;
    assign {load_d1, load_d0}   = ld_d;
    assign {d_in1, d_in0}       = dn;
    assign {load_v1, load_v0}   = ld_v;
    assign {v_in1, v_in0}       = vn;
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed checks of cache_control; inputs change on negedge,
// combinational outputs are sampled 1ns later, registered counters after the next edge.
module tb_cache_control;
    logic clk = 1'b0, rst;
    logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
    logic hit0, hit1, d_out0, d_out1, lru_out, load_lru, lru_in, pmemwdata_sel;
    logic load_d0, load_v0, load_TD0, d_in0, v_in0;
    logic load_d1, load_v1, load_TD1, d_in1, v_in1;
    logic [1:0] pmemaddr_sel;
    logic [15:0] hit_count, miss_count;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    cache_control dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit0(hit0), .hit1(hit1), .d_out0(d_out0), .d_out1(d_out1), .lru_out(lru_out),
        .load_lru(load_lru), .lru_in(lru_in), .pmemwdata_sel(pmemwdata_sel),
        .load_d0(load_d0), .load_v0(load_v0), .load_TD0(load_TD0), .d_in0(d_in0), .v_in0(v_in0),
        .load_d1(load_d1), .load_v1(load_v1), .load_TD1(load_TD1), .d_in1(d_in1), .v_in1(v_in1),
        .pmemaddr_sel(pmemaddr_sel), .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        {mem_read, mem_write, pmem_resp, hit0, hit1, d_out0, d_out1, lru_out} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();
        #1;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);

        // read hit on way1
        mem_read = 1; hit1 = 1; #1;
        chk("rh_mem_resp", mem_resp, 1);
        chk("rh_wdata_sel", pmemwdata_sel, 1);
        chk("rh_load_lru", load_lru, 1);
        chk("rh_lru_in", lru_in, 0);
        chk("rh_load_TD1", load_TD1, 0);
        @(negedge clk); clear_inputs(); #1;
        chk("rh_hit_count", hit_count, 1);
        chk("rh_idle_resp", mem_resp, 0);

        // clean miss read, victim way0
        do_reset();
        mem_read = 1; #1;
        chk("cm_no_resp", mem_resp, 0);
        chk("cm_no_load", load_TD0, 0);
        @(negedge clk); lru_out = 1; #1;
        chk("cm_pmem_read", pmem_read, 1);
        chk("cm_addr_sel", pmemaddr_sel, 2'b00);
        chk("cm_miss_count", miss_count, 1);
        repeat (4) @(negedge clk);
        #1 chk("cm_pmem_read_held", pmem_read, 1);
        chk("cm_no_early_load", load_TD0, 0);
        pmem_resp = 1; #1;
        chk("cm_load_TD0", load_TD0, 1);
        chk("cm_load_v0", load_v0, 1);
        chk("cm_v_in0", v_in0, 1);
        chk("cm_load_d0", load_d0, 1);
        chk("cm_d_in0", d_in0, 0);
        chk("cm_load_TD1", load_TD1, 0);
        @(negedge clk); pmem_resp = 0; hit0 = 1; #1;
        chk("cm_replay_resp", mem_resp, 1);
        chk("cm_replay_lru_in", lru_in, 1);
        chk("cm_replay_pmem_read", pmem_read, 0);
        @(negedge clk); clear_inputs(); #1;
        chk("cm_hit_count", hit_count, 0);
        chk("cm_miss_count_end", miss_count, 1);

        // dirty miss write, victim way1
        do_reset();
        mem_write = 1; lru_out = 1; d_out1 = 1;
        @(negedge clk); lru_out = 0; #1;
        chk("dm_pmem_write", pmem_write, 1);
        chk("dm_addr_sel", pmemaddr_sel, 2'b10);
        chk("dm_wdata_sel", pmemwdata_sel, 1);
        repeat (2) @(negedge clk);
        pmem_resp = 1; #1;
        chk("dm_pmem_write_held", pmem_write, 1);
        chk("dm_addr_sel_held", pmemaddr_sel, 2'b10);
        @(negedge clk); pmem_resp = 0; #1;
        chk("dm_alloc_read", pmem_read, 1);
        chk("dm_alloc_write", pmem_write, 0);
        chk("dm_alloc_addr", pmemaddr_sel, 2'b00);
        @(negedge clk); pmem_resp = 1; #1;
        chk("dm_fill_TD1", load_TD1, 1);
        chk("dm_fill_d_in1", d_in1, 0);
        @(negedge clk); pmem_resp = 0; hit1 = 1; #1;
        chk("dm_replay_resp", mem_resp, 1);
        chk("dm_replay_TD1", load_TD1, 1);
        chk("dm_replay_d1", load_d1, 1);
        chk("dm_replay_d_in1", d_in1, 1);
        chk("dm_replay_TD0", load_TD0, 0);
        @(negedge clk); clear_inputs(); #1;
        chk("dm_hit_count", hit_count, 0);
        chk("dm_miss_count", miss_count, 1);

        // reset during ALLOCATE
        do_reset();
        mem_read = 1;
        @(negedge clk); #1;
        chk("ra_pmem_read", pmem_read, 1);
        rst = 1; pmem_resp = 1; #1;
        chk("ra_no_load", load_TD0, 0);
        @(negedge clk); rst = 0; clear_inputs(); #1;
        chk("ra_pmem_read_off", pmem_read, 0);
        chk("ra_hit_count", hit_count, 0);
        chk("ra_miss_count", miss_count, 0);
        pmem_resp = 1;
        @(negedge clk); pmem_resp = 0; #1;
        chk("ra_stray_resp", pmem_read | pmem_write | mem_resp, 0);

        // both ways hit, read+write together acts as a write to way0
        mem_read = 1; mem_write = 1; hit0 = 1; hit1 = 1; #1;
        chk("bh_mem_resp", mem_resp, 1);
        chk("bh_load_TD0", load_TD0, 1);
        chk("bh_load_TD1", load_TD1, 0);
        chk("bh_d_in0", d_in0, 1);
        chk("bh_lru_in", lru_in, 1);
        chk("bh_wdata_sel", pmemwdata_sel, 0);

        // hit counter saturation
        do_reset();
        mem_read = 1; hit0 = 1;
        repeat (65535) @(negedge clk);
        #1 chk("sat_preload", hit_count, 16'hFFFF);
        @(negedge clk); #1;
        chk("sat_hold", hit_count, 16'hFFFF);
        chk("sat_miss_count", miss_count, 0);
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
